// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master arbiter.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARB       = 3'd1,
        LAUNCH    = 3'd2,
        WAIT_BUSY = 3'd3,
        XFER      = 3'd4,
        DONE      = 3'd5,
        ABORT     = 3'd6
    } arb_state_t;

    // Larger of two integers, used to size the shared watchdog counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: the first set request at or after i_ptr wins,
// wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // Scan from the farthest offset down to the pointer so the nearest request wins.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            logic [IW-1:0] w_j;
            w_j = IW'((int'(i_ptr) + k) % N);
            if (i_req[w_j]) begin
                o_onehot = N'(1) << w_j;
                o_idx    = w_j;
                o_any    = 1'b1;
            end else begin
                o_onehot = o_onehot;
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one i2c_master among NREQ requesters, with a
// start/transfer watchdog that resets the master when it stalls.
module i2c_master_arbiter
    import i2c_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int START_TO = 64,
    parameter int XFER_TO  = 65536
) (
    input  logic                       sysclk,
    input  logic                       reset_n,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            req_rw,
    input  logic [NREQ*I2C_ADDR_W-1:0] req_addr,
    input  logic [NREQ*I2C_DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            done,
    output logic [NREQ-1:0]            err,
    output logic [I2C_DATA_W-1:0]      rdata,
    output logic                       m_enable,
    output logic                       m_rw,
    output logic [I2C_ADDR_W-1:0]      m_address,
    output logic [I2C_DATA_W-1:0]      m_wdata,
    input  logic [I2C_DATA_W-1:0]      m_rdata,
    input  logic                       m_busy,
    output logic                       m_reset
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(max_int(START_TO, XFER_TO));
    localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TO - 1);
    localparam logic [CNT_W-1:0] XFER_LIM  = CNT_W'(XFER_TO - 1);

    arb_state_t              r_state;
    logic [PTR_W-1:0]        r_ptr;
    logic [CNT_W-1:0]        r_cnt;
    logic [NREQ-1:0]         r_gnt;
    logic [NREQ-1:0]         r_done;
    logic [NREQ-1:0]         r_err;
    logic [I2C_DATA_W-1:0]   r_rdata;
    logic                    r_m_enable;
    logic                    r_m_rw;
    logic [I2C_ADDR_W-1:0]   r_m_address;
    logic [I2C_DATA_W-1:0]   r_m_wdata;
    logic                    r_m_reset;

    logic [NREQ-1:0]         w_pick_onehot;
    logic [PTR_W-1:0]        w_pick_idx;
    logic                    w_pick_any;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic [I2C_ADDR_W-1:0]   w_addr_arr  [NREQ];
    logic [I2C_DATA_W-1:0]   w_wdata_arr [NREQ];

    // Unpack the flat per-requester buses so the winner can be selected by index.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_addr_arr[g]  = req_addr[g*I2C_ADDR_W +: I2C_ADDR_W];
        assign w_wdata_arr[g] = req_wdata[g*I2C_DATA_W +: I2C_DATA_W];
    end

    rr_pick #(
        .N  (NREQ),
        .IW (PTR_W)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // Watchdog counter saturates instead of wrapping.
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    // Arbitration / handshake sequencer with all outputs registered.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_err       <= '0;
            r_rdata     <= '0;
            r_m_enable  <= 1'b0;
            r_m_rw      <= 1'b0;
            r_m_address <= '0;
            r_m_wdata   <= '0;
            r_m_reset   <= 1'b0;
        end else begin
            r_done     <= '0;
            r_err      <= '0;
            r_m_enable <= 1'b0;
            r_m_reset  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_state <= ARB;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ARB: begin
                    if (w_pick_any) begin
                        r_m_rw      <= req_rw[w_pick_idx];
                        r_m_address <= w_addr_arr[w_pick_idx];
                        r_m_wdata   <= w_wdata_arr[w_pick_idx];
                        r_gnt       <= w_pick_onehot;
                        r_ptr       <= (w_pick_idx == PTR_W'(NREQ - 1)) ? '0 : w_pick_idx + 1'b1;
                        r_state     <= LAUNCH;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                LAUNCH: begin
                    r_m_enable <= 1'b1;
                    r_cnt      <= '0;
                    r_state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (m_busy) begin
                        r_cnt   <= '0;
                        r_state <= XFER;
                    end else if (r_cnt == START_LIM) begin
                        r_err     <= r_gnt;
                        r_m_reset <= 1'b1;
                        r_state   <= ABORT;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                XFER: begin
                    if (!m_busy) begin
                        r_done <= r_gnt;
                        if (r_m_rw) begin
                            r_rdata <= m_rdata;
                        end else begin
                            r_rdata <= r_rdata;
                        end
                        r_state <= DONE;
                    end else if (r_cnt == XFER_LIM) begin
                        r_err     <= r_gnt;
                        r_m_reset <= 1'b1;
                        r_state   <= ABORT;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                DONE, ABORT: begin
                    r_gnt   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign m_enable  = r_m_enable;
    assign m_rw      = r_m_rw;
    assign m_address = r_m_address;
    assign m_wdata   = r_m_wdata;
    assign m_reset   = r_m_reset;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Self-checking bench for i2c_master_arbiter with a behavioural i2c_master
// model and a transaction-level round-robin reference.
module tb_i2c_master_arbiter;

    localparam int NREQ     = 4;
    localparam int START_TO = 16;
    localparam int XFER_TO  = 200;

    logic        sysclk;
    logic        reset_n;
    logic [3:0]  req;
    logic [3:0]  req_rw;
    logic [27:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [3:0]  err;
    logic [7:0]  rdata;
    logic        m_enable;
    logic        m_rw;
    logic [6:0]  m_address;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata;
    logic        m_busy;
    logic        m_reset;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference state
    int          mptr = 0;
    logic [7:0]  exp_rdata = 8'h00;
    logic [6:0]  a_addr  [4];
    logic [7:0]  a_wdata [4];
    logic        a_rw    [4];

    // master model controls: mode 0 normal, 1 never busy, 2 busy stuck high
    int          mdl_mode  = 0;
    int          mdl_delay = 2;
    int          mdl_len   = 10;
    logic [7:0]  mdl_rdata = 8'h00;

    i2c_master_arbiter #(
        .NREQ     (NREQ),
        .START_TO (START_TO),
        .XFER_TO  (XFER_TO)
    ) dut (
        .sysclk    (sysclk),
        .reset_n   (reset_n),
        .req       (req),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .m_enable  (m_enable),
        .m_rw      (m_rw),
        .m_address (m_address),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_busy    (m_busy),
        .m_reset   (m_reset)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    always @(posedge sysclk) cyc <= cyc + 1;

    // Behavioural i2c_master: busy rises mdl_delay cycles after enable, lasts mdl_len cycles.
    initial begin : master_model
        int mcnt;
        bit active;
        m_busy  = 1'b0;
        m_rdata = 8'h00;
        mcnt    = 0;
        active  = 1'b0;
        forever begin
            @(negedge sysclk);
            if (reset_n !== 1'b1 || m_reset === 1'b1) begin
                active = 1'b0;
                m_busy = 1'b0;
            end else if (!active) begin
                if (m_enable === 1'b1) begin
                    active = 1'b1;
                    mcnt   = 0;
                end
            end else begin
                mcnt++;
                if (mdl_mode != 1 && mcnt == mdl_delay) begin
                    m_busy  = 1'b1;
                    m_rdata = mdl_rdata;
                end
                if (mdl_mode == 0 && mcnt == mdl_delay + mdl_len) begin
                    m_busy = 1'b0;
                    active = 1'b0;
                end
            end
        end
    end

    initial begin : time_guard
        #400000;
        $display("FAIL timeout: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requester at or after pointer p, wrapping.
    function automatic int rr_model(input logic [3:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (p + k) % NREQ;
            if (r[j[1:0]]) return j;
        end
        return -1;
    endfunction

    task automatic apply_fields();
        req_addr  = {a_addr[3], a_addr[2], a_addr[1], a_addr[0]};
        req_wdata = {a_wdata[3], a_wdata[2], a_wdata[1], a_wdata[0]};
        req_rw    = {a_rw[3], a_rw[2], a_rw[1], a_rw[0]};
    endtask

    task automatic rand_fields();
        foreach (a_addr[i]) begin
            a_addr[i]  = 7'($urandom);
            a_wdata[i] = 8'($urandom);
            a_rw[i]    = 1'($urandom);
        end
        apply_fields();
    endtask

    // One transaction, called at a negedge of an idle cycle with req already set.
    task automatic txn(input int pred, input int drop_at, input int tmo,
                       output bit got_done, output bit got_err, output int lat);
        logic [1:0] w;
        logic [3:0] oh;
        int t_en;
        bit seen;
        w  = pred[1:0];
        oh = 4'b0001 << w;
        @(negedge sysclk);
        chk("gnt_c1", 32'(gnt), 32'(4'b0000));
        @(negedge sysclk);
        chk("gnt_c2", 32'(gnt), 32'(oh));
        chk("enable_c2", 32'(m_enable), 32'(1'b0));
        @(negedge sysclk);
        chk("enable_c3", 32'(m_enable), 32'(1'b1));
        chk("m_address", 32'(m_address), 32'(a_addr[w]));
        chk("m_wdata", 32'(m_wdata), 32'(a_wdata[w]));
        chk("m_rw", 32'(m_rw), 32'(a_rw[w]));
        t_en = cyc;
        seen = 1'b0;
        for (int k = 0; k < tmo && !seen; k++) begin
            @(negedge sysclk);
            if (drop_at == k + 1) req[w] = 1'b0;
            if ((done | err) != 4'b0000) seen = 1'b1;
        end
        chk("end_seen", 32'(seen), 32'(1'b1));
        lat      = cyc - t_en;
        got_done = done[w];
        got_err  = err[w];
        chk("end_onehot", 32'(done | err), 32'(oh));
        chk("m_reset_w_err", 32'(m_reset), 32'(got_err));
        chk("gnt_at_end", 32'(gnt), 32'(oh));
        if (got_done && a_rw[w]) exp_rdata = mdl_rdata;
        chk("rdata_end", 32'(rdata), 32'(exp_rdata));
        @(negedge sysclk);
        chk("pulse_width", 32'(done | err), 32'(4'b0000));
        chk("gnt_release", 32'(gnt), 32'(4'b0000));
        chk("m_reset_width", 32'(m_reset), 32'(1'b0));
        mptr = (pred + 1) % NREQ;
    endtask

    initial begin : main
        bit d, e;
        int lat, pred;

        reset_n = 1'b0;
        req     = 4'b0000;
        foreach (a_addr[i]) begin
            a_addr[i]  = 7'h00;
            a_wdata[i] = 8'h00;
            a_rw[i]    = 1'b0;
        end
        apply_fields();
        repeat (3) @(negedge sysclk);
        chk("rst_gnt", 32'(gnt), 32'(4'b0000));
        chk("rst_done", 32'(done), 32'(4'b0000));
        chk("rst_err", 32'(err), 32'(4'b0000));
        chk("rst_enable", 32'(m_enable), 32'(1'b0));
        chk("rst_m_reset", 32'(m_reset), 32'(1'b0));
        chk("rst_m_rw", 32'(m_rw), 32'(1'b0));
        chk("rst_m_address", 32'(m_address), 32'(7'h00));
        chk("rst_m_wdata", 32'(m_wdata), 32'(8'h00));
        chk("rst_rdata", 32'(rdata), 32'(8'h00));
        reset_n = 1'b1;
        @(negedge sysclk);

        // single write from requester 2
        a_addr[2] = 7'h48; a_wdata[2] = 8'hA5; a_rw[2] = 1'b0;
        apply_fields();
        mdl_mode = 0; mdl_delay = 2; mdl_len = 10;
        req = 4'b0100;
        txn(rr_model(req, mptr), 0, 100, d, e, lat);
        chk("write_done", 32'(d), 32'(1'b1));
        chk("write_rdata_kept", 32'(rdata), 32'(8'h00));
        req = 4'b0000;

        // fairness from reset under full load
        reset_n = 1'b0;
        repeat (2) @(negedge sysclk);
        reset_n = 1'b1;
        mptr = 0;
        exp_rdata = 8'h00;
        rand_fields();
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            mdl_len = $urandom_range(1, 6);
            mdl_rdata = 8'($urandom);
            txn(i % 4, 0, 100, d, e, lat);
            chk("fair_done", 32'(d), 32'(1'b1));
        end
        req = 4'b0000;

        // read from requester 1
        a_addr[1] = 7'h21; a_rw[1] = 1'b1;
        apply_fields();
        mdl_rdata = 8'h3C; mdl_len = 5;
        req = 4'b0010;
        txn(rr_model(req, mptr), 0, 100, d, e, lat);
        chk("read_done", 32'(d), 32'(1'b1));
        chk("read_rdata", 32'(rdata), 32'(8'h3C));
        req = 4'b0000;
        repeat (5) @(negedge sysclk);
        chk("read_rdata_held", 32'(rdata), 32'(8'h3C));
        a_rw[3] = 1'b0;
        apply_fields();
        mdl_rdata = 8'h77;
        req = 4'b1000;
        txn(rr_model(req, mptr), 0, 100, d, e, lat);
        chk("rdata_after_write", 32'(rdata), 32'(8'h3C));
        req = 4'b0000;

        // randomized request patterns against the round-robin reference
        for (int i = 0; i < 16; i++) begin
            rand_fields();
            mdl_delay = $urandom_range(1, 4);
            mdl_len   = $urandom_range(1, 12);
            mdl_rdata = 8'($urandom);
            req = 4'($urandom_range(1, 15));
            pred = rr_model(req, mptr);
            txn(pred, 0, 100, d, e, lat);
            chk("rand_done", 32'(d), 32'(1'b1));
        end
        req = 4'b0000;

        // master never raises busy
        mdl_mode = 1;
        req = 4'b0001;
        txn(rr_model(req, mptr), 0, START_TO + 20, d, e, lat);
        chk("stall_err", 32'(e), 32'(1'b1));
        chk("stall_no_done", 32'(d), 32'(1'b0));
        chk("stall_latency", 32'(lat), 32'(START_TO));
        req = 4'b0000;

        // busy stuck high
        mdl_mode = 2; mdl_delay = 2;
        req = 4'b1000;
        txn(rr_model(req, mptr), 0, XFER_TO + 20, d, e, lat);
        chk("stuck_err", 32'(e), 32'(1'b1));
        chk("stuck_no_done", 32'(d), 32'(1'b0));
        chk("stuck_latency", 32'(lat), 32'(mdl_delay + 1 + XFER_TO));
        req = 4'b0000;

        // requester drops req during the transfer
        mdl_mode = 0; mdl_delay = 2; mdl_len = 10;
        req = 4'b0100;
        txn(rr_model(req, mptr), 5, 100, d, e, lat);
        chk("drop_done", 32'(d), 32'(1'b1));
        chk("drop_req_low", 32'(req), 32'(4'b0000));

        // reset asserted during the transfer
        mdl_len = 30;
        req = 4'b0100;
        pred = rr_model(req, mptr);
        @(negedge sysclk);
        @(negedge sysclk);
        chk("mr_gnt", 32'(gnt), 32'(4'b0100));
        @(negedge sysclk);
        chk("mr_enable", 32'(m_enable), 32'(1'b1));
        repeat (5) @(negedge sysclk);
        reset_n = 1'b0;
        #1;
        chk("mr_gnt_cleared", 32'(gnt), 32'(4'b0000));
        chk("mr_enable_low", 32'(m_enable), 32'(1'b0));
        chk("mr_addr_cleared", 32'(m_address), 32'(7'h00));
        for (int k = 0; k < 3; k++) begin
            @(negedge sysclk);
            chk("mr_no_done", 32'(done | err), 32'(4'b0000));
        end
        rand_fields();
        mdl_len = 4;
        req = 4'b1001;
        reset_n = 1'b1;
        mptr = 0;
        exp_rdata = 8'h00;
        txn(rr_model(req, mptr), 0, 100, d, e, lat);
        chk("mr_first_grant_done", 32'(d), 32'(1'b1));
        req = 4'b0000;
        repeat (2) @(negedge sysclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
